cpu_paddle_ctrl: RTL
====================

# cpu_paddle_ctrl

CPU-opponent paddle controller for the Pong game. It consumes the slow level clock produced by the CPU clock divider, detects its rising edges in the system clock domain, and moves the CPU paddle one bounded step per tick toward a target. The target is the ball while the ball approaches and screen centre otherwise. Its output `paddle_y` feeds collision logic and the pixel renderer.

## Interface
Parameters:
- `V_MAX`, 480: active screen height in pixels.
- `PAD_H`, 64: paddle height in pixels. Must be even and less than `V_MAX`.
- `STEP`, 4: maximum pixels moved per tick.
- `DEAD_ZONE`, 2: a target error at or below this value causes no movement.

Ports:
- `clk`, in, 1: system clock. The only clock in the block.
- `reset`, in, 1: synchronous, active-high reset.
- `cpu_clk`, in, 1: divided level clock from the CPU clock divider. It is a register output in the `clk` domain and is sampled as data, not used as a clock.
- `game_on`, in, 1: high while a rally is in play.
- `ball_toward`, in, 1: 1 when the ball's x-velocity points at the CPU paddle.
- `ball_y`, in, 10: ball centre row.
- `paddle_y`, out, 10: paddle top row.
- `step_pulse`, out, 1: one-cycle pulse, high in the cycle where `paddle_y` has just changed.
- `state`, out, 2: FSM state. IDLE=0, TRACK=1, RECENTER=2.

## Operation
- Constants: `CENTER = (V_MAX-PAD_H)/2` and `Y_MAX = V_MAX-PAD_H`.
- Tick detection: `tick = cpu_clk & ~cpu_clk_d`, where `cpu_clk_d` is `cpu_clk` delayed one `clk` cycle.
- FSM transitions are evaluated every `clk` cycle, not only on ticks:
  - `game_on=0` → IDLE.
  - `game_on=1` and `ball_toward=1` → TRACK.
  - `game_on=1` and `ball_toward=0` → RECENTER.
- IDLE: `paddle_y` is loaded with `CENTER` every cycle; ticks are ignored.
- Target selection:
  - TRACK: `tgt = clamp(ball_y - PAD_H/2, 0, Y_MAX)`, computed in 11-bit signed arithmetic. `ball_y < PAD_H/2` gives 0; `ball_y` of `V_MAX` or above gives `Y_MAX`.
  - RECENTER: `tgt = CENTER`.
- Movement on a tick in TRACK or RECENTER:
  - `err = tgt - paddle_y`, computed signed.
  - If `|err| <= DEAD_ZONE`: no change, no pulse.
  - Otherwise: `paddle_y` moves toward `tgt` by `min(STEP, |err|)`. There is never overshoot and never wrap.
- `paddle_y` always stays in `[0, Y_MAX]`.
- Priority: `reset` > IDLE entry > tick move.
  - A tick in the same cycle as a `game_on` fall is discarded; `paddle_y` becomes `CENTER`.
- A state change and a tick in the same cycle use the new state's target.

## Timing
- Reset values:
  - `paddle_y=CENTER`, `step_pulse=0`, `state=IDLE`.
  - `cpu_clk_d=1`. This suppresses a spurious tick if `cpu_clk` is high at reset release.
- Tick timing: if `cpu_clk` is registered high at edge N while `cpu_clk_d` is still 0, `tick` is high during cycle N→N+1. `paddle_y` and `step_pulse` update at edge N+1, giving 1-cycle latency.
- `step_pulse` is high for exactly one cycle per move. Tick spacing is 2×DIV `clk` cycles, so pulses never merge.
- State updates at the clock edge after the input change. IDLE recentering takes effect at that same edge.
- Reset mid-move: the next edge gives `paddle_y=CENTER` and `state=IDLE`, and the pending tick is lost.
- Maximum rate: `STEP` pixels per tick. A full sweep from 0 to `Y_MAX` takes `ceil(Y_MAX/STEP)` ticks.

## Structure
- Shared package `pong_pkg` holds:
  - `V_MAX` and `PAD_H`, shared with the ball, collision and render blocks.
  - The 2-bit state typedef with its encodings IDLE/TRACK/RECENTER.
- Sub-module `tick_rise_det`: the one-register rising-edge detector, with a reset-value parameter. It is reused wherever the team samples divided clocks.
- The FSM, target clamp and step saturation live in `cpu_paddle_ctrl`.

## Test plan
All scenarios use default parameters, so `CENTER=208` and `Y_MAX=416`.
- Reset with `cpu_clk` held high through release → `paddle_y=208`, `state=0`, no `step_pulse` on the first cycle.
- Ball at the bottom: `game_on=1`, `ball_toward=1`, `ball_y=400` (target 368) → `paddle_y` +4 per tick; exactly 40 pulses; holds at 368.
- Ball at the top: `ball_y=10` (target 0) → 52 ticks from 208 to 0; further ticks give no pulse and no wrap.
- Partial step: `paddle_y=208`, `ball_y=243` (target 211, err 3) → single move of 3 to 211, then hold.
- Dead zone: targets 209 and 210 (err 1 and 2) → no move, `step_pulse` stays 0.
- Recenter, then stop:
  - From 368, `ball_toward` falls → RECENTER; `paddle_y` decreases by 4 per tick.
  - `game_on` falls in the same cycle as a tick → `paddle_y=208` and `state=0` at the next edge, no pulse.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry and the CPU paddle FSM state encoding.
package pong_pkg;

    localparam int V_MAX = 480;
    localparam int PAD_H = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRACK    = 2'd1,
        ST_RECENTER = 2'd2
    } paddle_state_e;

endpackage

// File: rtl/tick_rise_det.sv
// One-register rising-edge detector for divided level clocks sampled as data in clk.
module tick_rise_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic tick
);

    logic sig_q;

    // Resetting high hides a level that is already high when reset is released.
    always_ff @(posedge clk) begin
        if (reset) sig_q <= RST_VAL;
        else       sig_q <= sig;
    end

    assign tick = sig & ~sig_q;

endmodule

// File: rtl/cpu_paddle_ctrl.sv
// CPU-opponent paddle: tracks the ball while it approaches, otherwise recentres,
// moving at most STEP pixels per divided-clock tick.
//
// state    | meaning
// IDLE     | no rally; paddle parked at CENTER, ticks ignored
// TRACK    | ball approaching; chase clamped ball-centred target
// RECENTER | ball receding; return to CENTER
module cpu_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int V_MAX     = pong_pkg::V_MAX,
    parameter int PAD_H     = pong_pkg::PAD_H,
    parameter int STEP      = 4,
    parameter int DEAD_ZONE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_clk,
    input  logic       game_on,
    input  logic       ball_toward,
    input  logic [9:0] ball_y,
    output logic [9:0] paddle_y,
    output logic       step_pulse,
    output logic [1:0] state
);

    localparam int CENTER = (V_MAX - PAD_H) / 2;
    localparam int Y_MAX  = V_MAX - PAD_H;

    localparam logic [9:0]         CENTER_V = 10'(CENTER);
    localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);
    localparam logic signed [10:0] HALF_S   = 11'(PAD_H / 2);
    localparam logic [10:0]        STEP_V   = 11'(STEP);
    localparam logic [10:0]        DZ_V     = 11'(DEAD_ZONE);

    paddle_state_e     state_q, state_d;
    logic [9:0]        paddle_q, paddle_mv;
    logic              pulse_q;
    logic              tick, move;
    logic signed [10:0] raw, err;
    logic [10:0]       abs_err;
    logic [9:0]        tgt, delta;

    tick_rise_det #(.RST_VAL(1'b1)) u_tick (
        .clk   (clk),
        .reset (reset),
        .sig   (cpu_clk),
        .tick  (tick)
    );

    // Target follows the next state so a state change and a tick in one cycle agree.
    always_comb begin
        state_d = ST_IDLE;
        if (game_on) state_d = ball_toward ? ST_TRACK : ST_RECENTER;

        raw = $signed({1'b0, ball_y}) - HALF_S;
        if (raw[10])            tgt = 10'd0;
        else if (raw > Y_MAX_S) tgt = Y_MAX_S[9:0];
        else                    tgt = raw[9:0];
        if (state_d == ST_RECENTER) tgt = CENTER_V;

        err       = $signed({1'b0, tgt}) - $signed({1'b0, paddle_q});
        abs_err   = err[10] ? 11'(-err) : 11'(err);
        move      = abs_err > DZ_V;
        delta     = (abs_err > STEP_V) ? STEP_V[9:0] : abs_err[9:0];
        paddle_mv = err[10] ? (paddle_q - delta) : (paddle_q + delta);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            paddle_q <= CENTER_V;
            pulse_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= 1'b0;
            if (state_d == ST_IDLE) begin
                paddle_q <= CENTER_V;
            end else if (tick && move) begin
                paddle_q <= paddle_mv;
                pulse_q  <= 1'b1;
            end
        end
    end

    assign paddle_y   = paddle_q;
    assign step_pulse = pulse_q;
    assign state      = state_q;

endmodule
